// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the E-stage multiply/divide unit.
// Also imported by ControlUnit_E to drive md_op.
package mdu_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic {S_IDLE, S_BUSY} mdu_state_e;

  // mult/multu/div/divu are the only ops with bit 2 clear
  function automatic logic is_long(input md_op_e op);
    return !op[2];
  endfunction
endpackage

// File: rtl/mult_div_unit_e_if.sv
// Pipeline-side bundle of the multiply/divide unit: request, operands,
// hazard inputs and the unit's status/result outputs.
interface mult_div_unit_e_if;
  import mdu_pkg::*;
  logic        start;
  md_op_e      md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_mult_div;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, rs_data, rt_data, d_mult_div,
                  input  busy, md_stall, md_result, hi, lo);
  modport slave  (input  start, md_op, rs_data, rt_data, d_mult_div,
                  output busy, md_stall, md_result, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator: products, quotient/remainder,
// and the divide-by-zero / signed-overflow rules.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e      md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] sq, sr, uq, ur;
  logic               div_zero, div_ovf;

  assign sprod    = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign uprod    = {32'b0, rs_data} * {32'b0, rt_data};
  assign div_zero = (rt_data == 32'd0);
  assign div_ovf  = (rs_data == 32'h8000_0000) && (rt_data == 32'hffff_ffff);

  // Divider inputs are steered away from the zero/overflow cases so the
  // operators never see them; the muxes below supply those results.
  always_comb begin
    sq = '0; sr = '0; uq = '0; ur = '0;
    if (!div_zero && !div_ovf) begin
      sq = $unsigned($signed(rs_data) / $signed(rt_data));
      sr = $unsigned($signed(rs_data) % $signed(rt_data));
    end
    if (!div_zero) begin
      uq = rs_data / rt_data;
      ur = rs_data % rt_data;
    end
  end

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (md_op)
      MD_MULT:  {res_hi, res_lo} = sprod;
      MD_MULTU: {res_hi, res_lo} = uprod;
      MD_DIV: if (div_ovf) begin
        res_hi = 32'd0;
        res_lo = 32'h8000_0000;
      end else if (!div_zero) begin
        res_hi = sr;
        res_lo = sq;
      end
      MD_DIVU: if (!div_zero) begin
        res_hi = ur;
        res_lo = uq;
      end
      MD_MTHI:  res_hi = rs_data;
      MD_MTLO:  res_lo = rs_data;
      default: ;
    endcase
  end
endmodule

// File: rtl/mult_div_unit_e.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency sequencing
// and the D-stage stall request. MDU_FAST_PATH_EN shortens trivial operands.
module mult_div_unit_e
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_e_if.slave md
);
  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_load;
  logic [31:0]       hi_q, lo_q, pend_hi, pend_lo, res_hi, res_lo;
  logic              idle, long_start, mt_start, is_mult;

  mdu_arith u_arith (
    .md_op   (md.md_op),
    .rs_data (md.rs_data),
    .rt_data (md.rt_data),
    .hi      (hi_q),
    .lo      (lo_q),
    .res_hi  (res_hi),
    .res_lo  (res_lo)
  );

  assign idle       = (state_q == S_IDLE);
  assign is_mult    = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);
  assign long_start = md.start && idle && is_long(md.md_op);
  assign mt_start   = md.start && idle && ((md.md_op == MD_MTHI) || (md.md_op == MD_MTLO));

  always_comb begin
    cnt_load = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
`ifdef MDU_FAST_PATH_EN
    if (is_mult && ((md.rs_data == 32'd0) || (md.rt_data == 32'd0)))
      cnt_load = CNT_W'(1);
    if (!is_mult && (md.rt_data == 32'd0))
      cnt_load = CNT_W'(1);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (long_start) state_d = S_BUSY;
      S_BUSY: if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Long results wait in pend_* and only reach HI/LO on the last busy edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      if (long_start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt_q   <= cnt_load;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end
      if (mt_start) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign md.busy      = (state_q == S_BUSY);
  assign md.md_stall  = md.d_mult_div && (md.busy || (md.start && is_long(md.md_op)));
  assign md.md_result = !md.start              ? 32'd0 :
                        (md.md_op == MD_MFHI) ? hi_q  :
                        (md.md_op == MD_MFLO) ? lo_q  : 32'd0;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
endmodule

// File: tb/tb_mult_div_unit_e.sv
// Self-checking bench for mult_div_unit_e: directed vectors plus random
// ops against an arithmetic HI/LO model (honours MDU_FAST_PATH_EN).
module tb_mult_div_unit_e;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] hi_m, lo_m;

  mult_div_unit_e_if md();

  mult_div_unit_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (op < 3'd2) ? MC : DC;
`ifdef MDU_FAST_PATH_EN
    if (op < 3'd2 && (a == 0 || b == 0)) n = 1;
    if (op >= 3'd2 && b == 0) n = 1;
`endif
    return n;
  endfunction

  // Architectural meaning of each op, from magnitudes and signs
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    logic [31:0] ma, mb, q, r;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = sp;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        {hi_m, lo_m} = up;
      end
      3'd2: if (b != 0) begin
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q = ma / mb;
        r = ma % mb;
        lo_m = (a[31] ^ b[31]) ? -q : q;
        hi_m = a[31] ? -r : r;
      end
      3'd3: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic long_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd, input logic inject);
    int n_exp, cnt;
    logic [31:0] hi_old;
    n_exp  = exp_lat(op, a, b);
    hi_old = hi_m;
    @(negedge clk);
    md.start = 1'b1; md.md_op = md_op_e'(op); md.rs_data = a; md.rt_data = b; md.d_mult_div = dmd;
    #1; checks++;
    if (md.md_stall !== dmd) begin
      errors++; $display("FAIL start_stall op=%0d got=%b exp=%b", op, md.md_stall, dmd);
    end
    @(negedge clk);
    if (inject) begin
      md.md_op = MD_MTHI; md.rs_data = $urandom;
    end else md.start = 1'b0;
    cnt = 0;
    while (md.busy === 1'b1 && cnt < 40) begin
      #1; checks++;
      if (md.md_stall !== dmd) begin
        errors++; $display("FAIL busy_stall op=%0d cyc=%0d got=%b exp=%b", op, cnt, md.md_stall, dmd);
      end
      if (cnt == 0) begin
        checks++;
        if (md.hi !== hi_old) begin
          errors++; $display("FAIL hi_early op=%0d got=%h exp=%h", op, md.hi, hi_old);
        end
      end
      @(negedge clk);
      md.start = 1'b0;
      cnt++;
    end
    md.start = 1'b0;
    model_apply(op, a, b);
    #1; checks++;
    if (md.md_stall !== 1'b0) begin
      errors++; $display("FAIL post_stall op=%0d got=%b exp=0", op, md.md_stall);
    end
    checks++;
    if (cnt != n_exp) begin
      errors++; $display("FAIL busy_len op=%0d a=%h b=%h got=%0d exp=%0d", op, a, b, cnt, n_exp);
    end
    checks++;
    if (md.hi !== hi_m || md.lo !== lo_m) begin
      errors++; $display("FAIL hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h", op, a, b, md.hi, md.lo, hi_m, lo_m);
    end
    md.d_mult_div = 1'b0;
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    md.start = 1'b1; md.md_op = md_op_e'(op); md.rs_data = a;
    @(negedge clk);
    md.start = 1'b0;
    model_apply(op, a, 32'd0);
    #1; checks++;
    if (md.busy !== 1'b0 || md.hi !== hi_m || md.lo !== lo_m) begin
      errors++; $display("FAIL mt op=%0d busy=%b got=%h_%h exp=%h_%h", op, md.busy, md.hi, md.lo, hi_m, lo_m);
    end
  endtask

  task automatic mf_check(input logic [2:0] op);
    logic [31:0] exp;
    exp = (op == 3'd6) ? hi_m : lo_m;
    @(negedge clk);
    md.start = 1'b1; md.md_op = md_op_e'(op);
    #1; checks++;
    if (md.md_result !== exp || md.busy !== 1'b0) begin
      errors++; $display("FAIL mf op=%0d got=%h exp=%h busy=%b", op, md.md_result, exp, md.busy);
    end
    md.start = 1'b0;
    #1; checks++;
    if (md.md_result !== 32'd0) begin
      errors++; $display("FAIL mf_idle got=%h exp=0", md.md_result);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    md.start = 1'b0; md.md_op = MD_MULT; md.rs_data = '0; md.rt_data = '0; md.d_mult_div = 1'b0;
    hi_m = '0; lo_m = '0;
    #12; checks++;
    if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0 || md.md_stall !== 1'b0 || md.md_result !== 32'd0) begin
      errors++; $display("FAIL reset busy=%b hi=%h lo=%h stall=%b res=%h", md.busy, md.hi, md.lo, md.md_stall, md.md_result);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_directed();
    long_op(3'd0, 32'hffff_fffe, 32'd3, 1'b0, 1'b0);
    long_op(3'd1, 32'hffff_fffe, 32'd3, 1'b0, 1'b0);
    long_op(3'd2, 32'hffff_fff9, 32'd2, 1'b0, 1'b0);
    long_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    long_op(3'd2, 32'h8000_0000, 32'hffff_ffff, 1'b0, 1'b0);
    long_op(3'd2, 32'd5, 32'd0, 1'b0, 1'b0);
    long_op(3'd0, 32'd0, 32'd5, 1'b0, 1'b0);
  endtask

  task automatic test_mt_mf();
    mt_op(3'd4, 32'h1234_5678);
    mf_check(3'd6);
    mt_op(3'd5, 32'hcafe_f00d);
    mf_check(3'd7);
    mf_check(3'd6);
  endtask

  task automatic test_stall();
    long_op(3'd0, 32'd9, 32'd11, 1'b1, 1'b0);
    long_op(3'd0, 32'd9, 32'd11, 1'b0, 1'b0);
    long_op(3'd3, 32'd1000, 32'd7, 1'b1, 1'b0);
  endtask

  task automatic test_ignored();
    long_op(3'd1, 32'hdead_beef, 32'h0bad_f00d, 1'b1, 1'b1);
    long_op(3'd2, 32'h7fff_0000, 32'hffff_fffd, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    mt_op(3'd4, 32'ha5a5_a5a5);
    mt_op(3'd5, 32'h5a5a_5a5a);
    @(negedge clk);
    md.start = 1'b1; md.md_op = MD_DIV; md.rs_data = 32'd100; md.rt_data = 32'd3;
    @(negedge clk); md.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    hi_m = '0; lo_m = '0;
    #1; checks++;
    if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid busy=%b hi=%h lo=%h", md.busy, md.hi, md.lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    long_op(3'd0, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [4];
    c[0] = 32'd0; c[1] = 32'h8000_0000; c[2] = 32'hffff_ffff; c[3] = 32'd1;
    return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 3)] : $urandom;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: mt_op(3'($urandom_range(4, 5)), $urandom);
        1: mf_check(3'($urandom_range(6, 7)));
        default: long_op(3'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_mf();
    test_stall();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
